// File: rtl/lsu_core.sv
// Load/store unit: one word-aligned bus transaction per op, lane steering for stores, extension for loads.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being aligned down.
module lsu_core #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [3:0]        op_reg;
  logic [4:0]        rd_reg;
  logic              err_reg;

  logic              fault_in;
  logic [1:0]        size_reg;
  logic              store_reg;
  logic              unsigned_reg;
  logic [1:0]        lane_off;
  logic [3:0][7:0]   lane_wdata;
  logic [3:0]        lane_strb;
  logic [DATA_W-1:0] rdata_shifted;
  logic [DATA_W-1:0] load_ext;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_in;
  assign misalign_in = ((req_op[1:0] == SZ_HALF) && req_addr[0]) ||
                       ((req_op[1:0] == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign fault_in    = (req_op[1:0] == SZ_RSVD) || misalign_in;
`else
  assign fault_in    = (req_op[1:0] == SZ_RSVD);
`endif

  assign size_reg     = op_reg[1:0];
  assign unsigned_reg = op_reg[2];
  assign store_reg    = op_reg[3];

  // Misaligned halves/words are aligned down for lane selection.
  always_comb begin
    case (size_reg)
      SZ_BYTE: lane_off = addr_reg[1:0];
      SZ_HALF: lane_off = {addr_reg[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_wdata[gi] = (size_reg == SZ_BYTE) ? wdata_reg[7:0] :
                            (size_reg == SZ_HALF) ? wdata_reg[8*(gi%2) +: 8] :
                                                    wdata_reg[8*gi +: 8];
    assign lane_strb[gi]  = ((size_reg == SZ_BYTE) && (lane_off == 2'(gi))) ||
                            ((size_reg == SZ_HALF) && (lane_off[1] == 1'(gi/2))) ||
                            (size_reg == SZ_WORD);
  end

  assign rdata_shifted = rdata_reg >> {lane_off, 3'b000};

  always_comb begin
    case (size_reg)
      SZ_BYTE: load_ext = {{24{~unsigned_reg & rdata_shifted[7]}}, rdata_shifted[7:0]};
      SZ_HALF: load_ext = {{16{~unsigned_reg & rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_ext = rdata_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      op_reg    <= '0;
      rd_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid) begin
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        op_reg    <= req_op;
        rd_reg    <= req_rd;
        err_reg   <= fault_in;
      end
      if (state_reg == RESP && mem_rsp_valid) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    wb_valid      = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = fault_in ? DONE : REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = RESP;
      end
      RESP: begin
        if (mem_rsp_valid) state_next = DONE;
      end
      DONE: begin
        wb_valid   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus fields are only driven while a request is presented.
  assign mem_addr  = (state_reg == REQ) ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wen   = (state_reg == REQ) && store_reg;
  assign mem_wdata = ((state_reg == REQ) && store_reg) ? lane_wdata : '0;
  assign mem_wstrb = ((state_reg == REQ) && store_reg) ? lane_strb : 4'b0000;

  assign wb_we   = (state_reg == DONE) && !err_reg && !store_reg;
  assign wb_rd   = (state_reg == DONE) ? rd_reg : 5'd0;
  assign wb_data = wb_we ? load_ext : '0;
  assign err     = (state_reg == DONE) && err_reg;

endmodule

// File: tb/tb_lsu_core.sv
// Self-checking bench for lsu_core: directed cases plus randomized ops against an arithmetic model.
module tb_lsu_core;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_op;
  logic [4:0]        req_rd;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_valid;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              err;

  always #5 clk = ~clk;

  lsu_core #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_op(req_op), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // Observations of one transaction
  int          o_wb_cycle;
  logic        o_we, o_err, o_bus, o_stable, o_wen, o_after_wb, o_after_ready;
  logic [4:0]  o_rd;
  logic [31:0] o_data, o_addr, o_wdata;
  logic [3:0]  o_wstrb;

  // Model expectations
  logic        e_err, e_we, e_bus;
  logic [31:0] e_data, e_addr, e_wdata;
  logic [3:0]  e_wstrb;
  int          e_lat;

  task automatic model_op(input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input logic [3:0] op,
                          input int rs, input int ps);
    int n, o;
    logic [31:0] mask, v;
    n = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    e_err = (op[1:0] == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((addr % n) != 0) e_err = 1'b1;
`endif
    o = int'(addr % 4);
    o = o - (o % n);
    e_addr  = addr - (addr % 4);
    e_bus   = !e_err;
    mask    = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    e_wstrb = 4'(((1 << n) - 1) << o);
    e_wdata = (n == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
              (n == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    v = (rdata >> (8 * o)) & mask;
    if (!op[2] && n < 4 && v[8 * n - 1]) v = v | ~mask;
    e_we   = !e_err && !op[3];
    e_data = e_we ? v : 32'd0;
    e_lat  = e_err ? 1 : 3 + rs + ps;
  endtask

  // Issues one op from IDLE, plays the bus with rs ready stalls and ps response stalls,
  // and returns one cycle after the completion pulse.
  task automatic run_op(input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input logic [3:0] op,
                        input logic [4:0] rd, input int rs, input int ps, input bit noise);
    int cyc, rcnt, pcnt;
    bit phase_resp, go_resp, first;
    req_valid = 1'b1; req_addr = addr; req_wdata = wd; req_op = op; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_op = 4'($urandom); req_rd = 5'($urandom);
    cyc = 1; rcnt = 0; pcnt = 0; phase_resp = 0; first = 1;
    o_bus = 0; o_stable = 1; o_wb_cycle = -1;
    o_we = 0; o_err = 0; o_rd = 0; o_data = 0; o_addr = 0; o_wdata = 0; o_wstrb = 0; o_wen = 0;
    while (cyc < 40) begin
      go_resp = 0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rdata = $urandom;
      if (wb_valid) begin
        o_wb_cycle = cyc; o_we = wb_we; o_err = err; o_rd = wb_rd; o_data = wb_data;
        break;
      end
      if (mem_req_valid) begin
        if (first) begin
          o_addr = mem_addr; o_wen = mem_wen; o_wdata = mem_wdata; o_wstrb = mem_wstrb;
          o_bus = 1; first = 0;
        end else if (mem_addr !== o_addr || mem_wen !== o_wen || mem_wdata !== o_wdata ||
                     mem_wstrb !== o_wstrb) begin
          o_stable = 0;
        end
        mem_req_ready = (rcnt == rs);
        go_resp = mem_req_ready;
        rcnt++;
        if (noise) mem_rsp_valid = 1'($urandom_range(0, 1));
      end else if (phase_resp) begin
        mem_rsp_valid = (pcnt == ps);
        if (mem_rsp_valid) mem_rdata = rdata;
        pcnt++;
      end else if (noise) begin
        mem_rsp_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
      if (go_resp) phase_resp = 1;
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    o_after_wb = wb_valid;
    o_after_ready = req_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 0; req_addr = 0; req_wdata = 0; req_op = 0; req_rd = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++;
    if ({mem_req_valid, mem_wen, wb_valid, wb_we, err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {mem_req_valid, mem_wen, wb_valid, wb_we, err});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb, wb_data, wb_rd} !== '0) begin
      errors++; $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, mem_wstrb, wb_data, wb_rd});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: req_ready=%b", req_ready);
  endtask

  task automatic test_load_word();
    run_op(32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 4'b0010, 5'd7, 0, 0, 0);
    $display("lw 80000004: wb_cycle=%0d we=%b data=%h addr=%h", o_wb_cycle, o_we, o_data, o_addr);
    checks++;
    if (o_wb_cycle != 3) begin errors++; $display("FAIL lw_latency got %0d want 3", o_wb_cycle); end
    checks++;
    if (o_we !== 1'b1 || o_data !== 32'hDEAD_BEEF || o_rd !== 5'd7) begin
      errors++; $display("FAIL lw_wb got we=%b data=%h rd=%0d want 1 deadbeef 7", o_we, o_data, o_rd);
    end
    checks++;
    if (o_addr !== 32'h8000_0004 || o_wen !== 1'b0 || o_wstrb !== 4'b0) begin
      errors++; $display("FAIL lw_bus got addr=%h wen=%b strb=%b want 80000004 0 0000", o_addr, o_wen, o_wstrb);
    end
  endtask

  task automatic test_load_byte();
    run_op(32'h1000_0003, 32'h0, 32'h80FF_0000, 4'b0000, 5'd3, 0, 0, 0);
    $display("lb 10000003: data=%h", o_data);
    checks++;
    if (o_data !== 32'hFFFF_FF80 || o_we !== 1'b1) begin
      errors++; $display("FAIL lb_sign got %h want ffffff80", o_data);
    end
    run_op(32'h1000_0003, 32'h0, 32'h80FF_0000, 4'b0100, 5'd3, 0, 0, 0);
    $display("lbu 10000003: data=%h", o_data);
    checks++;
    if (o_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu_zero got %h want 00000080", o_data); end
  endtask

  task automatic test_store_half();
    run_op(32'h2000_0002, 32'h1234_ABCD, 32'h5555_5555, 4'b1001, 5'd9, 0, 0, 0);
    $display("sh 20000002: strb=%b wdata=%h wen=%b we=%b", o_wstrb, o_wdata, o_wen, o_we);
    checks++;
    if (o_wstrb !== 4'b1100 || o_wdata !== 32'hABCD_ABCD || o_wen !== 1'b1) begin
      errors++; $display("FAIL sh_bus got strb=%b wdata=%h wen=%b want 1100 abcdabcd 1", o_wstrb, o_wdata, o_wen);
    end
    checks++;
    if (o_we !== 1'b0 || o_data !== 32'd0 || o_err !== 1'b0) begin
      errors++; $display("FAIL sh_wb got we=%b data=%h err=%b want 0 0 0", o_we, o_data, o_err);
    end
  endtask

  task automatic test_stall();
    run_op(32'h3000_0010, 32'hCAFE_F00D, 32'h0, 4'b1010, 5'd1, 3, 0, 1);
    $display("sw stall3: wb_cycle=%0d stable=%b", o_wb_cycle, o_stable);
    checks++;
    if (o_wb_cycle != 6) begin errors++; $display("FAIL stall_latency got %0d want 6", o_wb_cycle); end
    checks++;
    if (o_stable !== 1'b1 || o_wdata !== 32'hCAFE_F00D || o_wstrb !== 4'b1111) begin
      errors++; $display("FAIL stall_stable got stable=%b wdata=%h strb=%b want 1 cafef00d 1111", o_stable, o_wdata, o_wstrb);
    end
  endtask

  task automatic test_misalign();
    run_op(32'h4000_0001, 32'h0, 32'h1122_3344, 4'b0010, 5'd5, 0, 0, 0);
    $display("lw 40000001: wb_cycle=%0d err=%b bus=%b data=%h", o_wb_cycle, o_err, o_bus, o_data);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (o_wb_cycle != 1 || o_err !== 1'b1 || o_bus !== 1'b0 || o_we !== 1'b0 || o_data !== 32'd0) begin
      errors++; $display("FAIL misalign_trap got cyc=%0d err=%b bus=%b want 1 1 0", o_wb_cycle, o_err, o_bus);
    end
`else
    checks++;
    if (o_wb_cycle != 3 || o_err !== 1'b0 || o_addr !== 32'h4000_0000 || o_data !== 32'h1122_3344) begin
      errors++; $display("FAIL misalign_align got cyc=%0d err=%b addr=%h data=%h want 3 0 40000000 11223344",
                         o_wb_cycle, o_err, o_addr, o_data);
    end
`endif
  endtask

  task automatic test_reset_in_resp();
    int seen_wb;
    req_valid = 1'b1; req_addr = 32'h5000_0008; req_op = 4'b0010; req_rd = 5'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rstresp_req got %b want 1", mem_req_valid); end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    checks++;
    if (req_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL rstresp_idle got ready=%b wb=%b want 1 0", req_ready, wb_valid);
    end
    seen_wb = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      if (wb_valid) seen_wb++;
    end
    $display("reset in RESP: req_ready=%b stray_wb=%0d", req_ready, seen_wb);
    checks++;
    if (seen_wb != 0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rstresp_nowb got wb=%0d ready=%b want 0 1", seen_wb, req_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, wd, rdata;
    logic [3:0]  op;
    logic [4:0]  rd;
    int rs, ps;
    for (int i = 0; i < 60; i++) begin
      addr  = $urandom;
      wd    = $urandom;
      rdata = $urandom;
      rd    = 5'($urandom);
      op    = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2))};
      rs    = $urandom_range(0, 2);
      ps    = $urandom_range(0, 2);
      model_op(addr, wd, rdata, op, rs, ps);
      run_op(addr, wd, rdata, op, rd, rs, ps, 1);
      $display("rand %0d: addr=%h op=%b rs=%0d ps=%0d -> cyc=%0d err=%b we=%b data=%h strb=%b wdata=%h",
               i, addr, op, rs, ps, o_wb_cycle, o_err, o_we, o_data, o_wstrb, o_wdata);
      checks++;
      if (o_wb_cycle != e_lat) begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", i, o_wb_cycle, e_lat); end
      checks++;
      if (o_err !== e_err || o_we !== e_we || o_data !== e_data || o_rd !== rd) begin
        errors++; $display("FAIL rand_wb[%0d] got err=%b we=%b data=%h rd=%0d want %b %b %h %0d",
                           i, o_err, o_we, o_data, o_rd, e_err, e_we, e_data, rd);
      end
      checks++;
      if (o_bus !== e_bus) begin errors++; $display("FAIL rand_bus[%0d] got %b want %b", i, o_bus, e_bus); end
      if (e_bus) begin
        checks++;
        if (o_addr !== e_addr || o_wen !== op[3] || o_stable !== 1'b1) begin
          errors++; $display("FAIL rand_req[%0d] got addr=%h wen=%b stable=%b want %h %b 1", i, o_addr, o_wen, o_stable, e_addr, op[3]);
        end
        checks++;
        if (op[3] && (o_wstrb !== e_wstrb || o_wdata !== e_wdata)) begin
          errors++; $display("FAIL rand_store[%0d] got strb=%b wdata=%h want %b %h", i, o_wstrb, o_wdata, e_wstrb, e_wdata);
        end else if (!op[3] && o_wstrb !== 4'b0) begin
          errors++; $display("FAIL rand_store[%0d] got strb=%b want 0000", i, o_wstrb);
        end
      end
      checks++;
      if (o_after_wb !== 1'b0 || o_after_ready !== 1'b1) begin
        errors++; $display("FAIL rand_done[%0d] got wb=%b ready=%b want 0 1", i, o_after_wb, o_after_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_stall();
    test_misalign();
    test_reset_in_resp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_core.md
# lsu_core

Load/store unit sitting directly downstream of the execute-stage ALU: takes the ALU's computed effective address plus store data and a memory opcode, issues one word-aligned bus transaction over a valid/ready handshake, and returns write-enable-aligned store data or sign/zero-extended load data to writeback. One operation is in flight at a time. A four-state FSM sequences request, response and writeback.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, data width; only 32 is supported.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents an op.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_W  effective address (ALU add result).
- req_wdata  in  DATA_W  store source (rs2).
- req_op  in  4  bit3 store, bit2 unsigned load, bits[1:0] size: 00 byte, 01 half, 10 word, 11 reserved.
- req_rd  in  5  load destination register.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts request.
- mem_addr  out  ADDR_W  {req_addr[ADDR_W-1:2], 2'b00}.
- mem_wen  out  1  store request.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_wstrb  out  4  byte strobes; 0 for loads.
- mem_rsp_valid  in  1  read data / write ack.
- mem_rdata  in  DATA_W  read word.
- wb_valid  out  1  one-cycle completion pulse.
- wb_we  out  1  register write (loads without error).
- wb_rd  out  5  latched req_rd.
- wb_data  out  DATA_W  extended load data; 0 for stores/errors.
- err  out  1  misaligned/reserved-size fault, valid with wb_valid.

## Operation
- States: IDLE, REQ, RESP, DONE. Reset -> IDLE; all outputs 0 except req_ready=1.
- IDLE: req_valid&req_ready latches addr, wdata, op, rd -> REQ (or DONE with err, see Configuration).
- REQ: mem_req_valid=1, mem_addr/mem_wen/mem_wdata/mem_wstrb held stable until mem_req_ready; then -> RESP.
- RESP: wait mem_rsp_valid; capture mem_rdata -> DONE. Stores also wait for the ack.
- DONE: wb_valid=1 for exactly one cycle -> IDLE.
- Store lanes (o = addr[1:0]): byte wstrb=4'b0001<<o, wdata={4{d[7:0]}}; half wstrb=4'b0011<<o, wdata={2{d[15:0]}}; word wstrb=4'b1111, wdata=d.
- Load extract: byte = rdata[8*o+:8]; half = rdata[8*o+:16]; word = rdata. Sign-extend unless bit2 set.
- mem_rsp_valid outside RESP ignored. Reserved size 11 always faults.
- rst in any state -> IDLE next edge; outstanding bus response discarded; no wb_valid.

## Timing
- Accept at cycle 0 -> mem_req_valid cycle 1 -> earliest RESP cycle 2 -> earliest mem_rsp_valid cycle 2 -> wb_valid cycle 3. Minimum latency 3 cycles; each ready/rsp stall adds one.
- Fault path: accept cycle 0 -> wb_valid+err cycle 1; no bus activity.
- req_ready next high the cycle after DONE (back-to-back issue every 4 cycles minimum).

## Configuration
- LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 goes IDLE->DONE with err=1, wb_we=0, wb_data=0, no bus request.
- Undefined: misaligned addresses are aligned down (half clears addr[0], word clears addr[1:0]) for lane selection and proceed normally; err only for reserved size.

## Test plan
- lw addr 0x8000_0004, rdata 0xDEAD_BEEF, ready and rsp immediate -> wb_valid at cycle 3, wb_we=1, wb_data 0xDEADBEEF, mem_addr 0x8000_0004.
- lb addr 0x...0003, rdata 0x80FF_0000 -> wb_data 0xFFFF_FF80; lbu same -> 0x0000_0080.
- sh addr 0x...0002, wdata 0x1234_ABCD -> mem_wstrb 4'b1100, mem_wdata 0xABCD_ABCD, mem_wen=1, wb_we=0.
- mem_req_ready low 3 cycles -> request fields stable throughout, wb_valid at cycle 6.
- lw addr 0x...0001: with LSU_MISALIGN_TRAP_EN -> wb_valid+err cycle 1, mem_req_valid never high; without -> mem_addr 0x...0000, normal load.
- rst asserted in RESP, stray mem_rsp_valid next cycle -> IDLE, req_ready=1, no wb_valid.
